// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered channel multiplexer.
package mux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Select/index width for n channels, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last-served channel, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SELW   = sel_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SELW-1:0]   last,
  output logic [NUM_CH-1:0] grant_c,
  output logic [SELW-1:0]   grant_idx_c
);

  logic [SELW-1:0] idx;
  logic            found;

  // Search order: last+1, last+2, ... wrapping to last itself.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = SELW'((32'(last) + k) % NUM_CH);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N:1 channel multiplexer with a single output register; external select or round-robin.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned MODE   = MODE_SEL,
  localparam int unsigned SELW   = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SELW-1:0]         sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SELW-1:0]         out_ch
);

  localparam int unsigned PADW = 1 << SELW;

  logic              load_c;
  logic              xfer_c;
  logic              gnt_valid_c;
  logic [NUM_CH-1:0] gnt_c;
  logic [SELW-1:0]   gnt_idx_c;
  logic [WIDTH-1:0]  sel_data_c;

  assign load_c   = !out_valid || out_ready;
  assign xfer_c   = load_c && gnt_valid_c;
  assign in_ready = (rst_n && xfer_c) ? gnt_c : '0;

  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] last_q;
    logic            unused_sel;

    assign unused_sel = ^sel;

    // Pointer moves only on a real transfer; reset makes channel 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_q <= SELW'(NUM_CH - 1);
      end else if (xfer_c) begin
        last_q <= gnt_idx_c;
      end
    end

    rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SELW   (SELW)
    ) u_arb (
      .req         (in_valid),
      .last        (last_q),
      .grant_c     (gnt_c),
      .grant_idx_c (gnt_idx_c)
    );

    assign gnt_valid_c = |gnt_c;
  end else begin : g_sel
    logic [PADW-1:0] valid_pad;
    logic [PADW-1:0] oh_pad;

    // Pad to the full select range so out-of-range codes index safely.
    always_comb begin
      valid_pad   = PADW'(in_valid);
      oh_pad      = '0;
      oh_pad[sel] = 1'b1;
    end

    assign gnt_idx_c   = sel;
    assign gnt_valid_c = (32'(sel) < NUM_CH) && valid_pad[sel];
    assign gnt_c       = NUM_CH'(oh_pad);
  end

  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_idx_c == SELW'(i)) begin
        sel_data_c = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on transfer, drain to empty when nothing is granted, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_c) begin
      out_valid <= gnt_valid_c;
      if (gnt_valid_c) begin
        out_data <= sel_data_c;
        out_ch   <= gnt_idx_c;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: three configurations driven side by side against a behavioural model.
module tb_mux_nto1_rr;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] s4_data;  logic [3:0] s4_valid, s4_ird; logic [1:0] s4_sel, s4_och;
  logic [7:0]  s4_odata; logic s4_ov, s4_ordy;
  logic [23:0] s3_data;  logic [2:0] s3_valid, s3_ird; logic [1:0] s3_sel, s3_och;
  logic [7:0]  s3_odata; logic s3_ov, s3_ordy;
  logic [31:0] rr_data;  logic [3:0] rr_valid, rr_ird; logic [1:0] rr_sel, rr_och;
  logic [7:0]  rr_odata; logic rr_ov, rr_ordy;

  mux_nto1_rr #(.WIDTH(8), .NUM_CH(4), .MODE(MODE_SEL)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_data(s4_data), .in_valid(s4_valid), .in_ready(s4_ird),
    .sel(s4_sel), .out_data(s4_odata), .out_valid(s4_ov), .out_ready(s4_ordy), .out_ch(s4_och));
  mux_nto1_rr #(.WIDTH(8), .NUM_CH(3), .MODE(MODE_SEL)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_data(s3_data), .in_valid(s3_valid), .in_ready(s3_ird),
    .sel(s3_sel), .out_data(s3_odata), .out_valid(s3_ov), .out_ready(s3_ordy), .out_ch(s3_och));
  mux_nto1_rr #(.WIDTH(8), .NUM_CH(4), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(rr_data), .in_valid(rr_valid), .in_ready(rr_ird),
    .sel(rr_sel), .out_data(rr_odata), .out_valid(rr_ov), .out_ready(rr_ordy), .out_ch(rr_och));

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance (0 = s4, 1 = s3, 2 = rr).
  bit   m_ov[3];
  logic [7:0] m_od[3];
  int   m_oc[3];
  int   m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int g_sel(input int n, input int s, input logic [3:0] v);
    if (s < n && v[s[1:0]]) return s;
    return -1;
  endfunction

  function automatic int g_rr(input int n, input int last, input logic [3:0] v);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (last + k) % n;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdy(input bit ld, input int g);
    return (ld && g >= 0) ? (32'd1 << g) : 32'd0;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      m_ov[i] = 1'b0; m_od[i] = 8'h00; m_oc[i] = 0;
    end
    m_last = 3;
  endtask

  task automatic chk_out(input string nm, input int i, input logic ov, input logic [7:0] od,
                         input logic [1:0] oc);
    chk({nm, "_out_valid"}, 32'(ov), 32'(m_ov[i]));
    chk({nm, "_out_data"},  32'(od), 32'(m_od[i]));
    chk({nm, "_out_ch"},    32'(oc), 32'(m_oc[i]));
  endtask

  // One clock: check in_ready before the edge, advance the model, check registers after.
  task automatic cycle();
    int g[3]; bit ld[3]; logic [3:0] v[3]; logic [31:0] d[3];
    #1;
    v[0] = s4_valid; v[1] = {1'b0, s3_valid}; v[2] = rr_valid;
    d[0] = s4_data;  d[1] = {8'h00, s3_data}; d[2] = rr_data;
    ld[0] = !m_ov[0] || s4_ordy;
    ld[1] = !m_ov[1] || s3_ordy;
    ld[2] = !m_ov[2] || rr_ordy;
    g[0] = g_sel(4, int'(s4_sel), v[0]);
    g[1] = g_sel(3, int'(s3_sel), v[1]);
    g[2] = g_rr(4, m_last, v[2]);
    chk("s4_in_ready", 32'(s4_ird), exp_rdy(ld[0], g[0]));
    chk("s3_in_ready", 32'(s3_ird), exp_rdy(ld[1], g[1]));
    chk("rr_in_ready", 32'(rr_ird), exp_rdy(ld[2], g[2]));
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (ld[i]) begin
        if (g[i] >= 0) begin
          m_ov[i] = 1'b1;
          m_od[i] = 8'(d[i] >> (8 * g[i]));
          m_oc[i] = g[i];
          if (i == 2) m_last = g[i];
        end else begin
          m_ov[i] = 1'b0;
        end
      end
    end
    #1;
    chk_out("s4", 0, s4_ov, s4_odata, s4_och);
    chk_out("s3", 1, s3_ov, s3_odata, s3_och);
    chk_out("rr", 2, rr_ov, rr_odata, rr_och);
  endtask

  // Asynchronous reset: outputs clear at once, released away from the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("rst_s4_ov", 32'(s4_ov), 32'd0);
    chk("rst_rr_ov", 32'(rr_ov), 32'd0);
    chk("rst_s3_ov", 32'(s3_ov), 32'd0);
    chk("rst_rr_data", 32'(rr_odata), 32'd0);
    chk("rst_rr_ch", 32'(rr_och), 32'd0);
    chk("rst_s4_ird", 32'(s4_ird), 32'd0);
    chk("rst_rr_ird", 32'(rr_ird), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] last_word;

  initial begin
    s4_data = '0; s4_valid = '0; s4_sel = '0; s4_ordy = 1'b0;
    s3_data = '0; s3_valid = '0; s3_sel = '0; s3_ordy = 1'b0;
    rr_data = '0; rr_valid = '0; rr_sel = '0; rr_ordy = 1'b0;
    rr_valid = 4'hF; rr_ordy = 1'b1; s4_valid = 4'hF;
    do_reset();
    rr_valid = '0; s4_valid = '0;

    // Fixed select on channel 2; 3-channel instance loads channel 1 first.
    s4_sel = 2'd2; s4_data = 32'h44A5_2211; s4_valid = 4'hF; s4_ordy = 1'b1;
    s3_sel = 2'd1; s3_data = 24'h33_7E_11; s3_valid = 3'b111; s3_ordy = 1'b1;
    #1;
    chk("sc1_in_ready", 32'(s4_ird), 32'h4);
    cycle();
    chk("sc1_data", 32'(s4_odata), 32'hA5);
    chk("sc1_ch", 32'(s4_och), 32'd2);
    chk("sc2_pre_ov", 32'(s3_ov), 32'd1);

    // Out-of-range select on the 3-channel instance: no grant, output drains.
    s3_sel = 2'd3;
    #1;
    chk("sc2_in_ready", 32'(s3_ird), 32'd0);
    cycle();
    chk("sc2_ov", 32'(s3_ov), 32'd0);
    chk("sc2_hold_data", 32'(s3_odata), 32'h7E);

    // Round-robin rotation with everyone requesting.
    do_reset();
    rr_valid = 4'hF; rr_ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rr_data = $urandom;
      last_word = 8'(rr_data >> (8 * (k % 4)));
      cycle();
      chk("sc3_ch", 32'(rr_och), 32'(k % 4));
      chk("sc3_data", 32'(rr_odata), 32'(last_word));
    end

    // Stall with channels 1 and 3 pending, then release.
    rr_valid = 4'b1010; rr_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rr_data = $urandom;
      #1;
      chk("sc4_stall_ird", 32'(rr_ird), 32'd0);
      cycle();
      chk("sc4_frozen", 32'(rr_odata), 32'(last_word));
      chk("sc4_frozen_ch", 32'(rr_och), 32'd3);
    end
    rr_ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("sc4_order", 32'(rr_och), (k == 1) ? 32'd3 : 32'd1);
    end

    // Single requester back to back: one word every cycle.
    rr_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      rr_data = $urandom;
      cycle();
      chk("sc5_ov", 32'(rr_ov), 32'd1);
      chk("sc5_data", 32'(rr_odata), 32'(rr_data[7:0]));
    end

    // Reset while a word is held; first grant afterwards is channel 0.
    rr_valid = 4'hF; rr_ordy = 1'b0;
    cycle();
    chk("sc6_pre_ov", 32'(rr_ov), 32'd1);
    do_reset();
    rr_data = $urandom;
    cycle();
    chk("sc6_first_ch", 32'(rr_och), 32'd0);
    chk("sc6_first_ov", 32'(rr_ov), 32'd1);

    // Randomized traffic on all three instances.
    for (int k = 0; k < 250; k++) begin
      s4_sel = 2'($urandom_range(0, 3)); s3_sel = 2'($urandom_range(0, 3));
      s4_valid = 4'($urandom); s3_valid = 3'($urandom); rr_valid = 4'($urandom);
      s4_data = $urandom; s3_data = 24'($urandom); rr_data = $urandom;
      s4_ordy = ($urandom_range(0, 3) != 0);
      s3_ordy = ($urandom_range(0, 3) != 0);
      rr_ordy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
